// File: rtl/foc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | foc_pkg : FSM encoding, datapath widths and saturation helper for FOC loops |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
package foc_pkg;

  localparam int SPEED_W = 16;
  localparam int IQ_W    = 12;
  localparam int GAIN_W  = 10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ERR   = 3'd1,
    ST_MUL_P = 3'd2,
    ST_MUL_I = 3'd3,
    ST_ACC   = 3'd4,
    ST_OUT   = 3'd5
  } pi_state_e;

  // Symmetric clamp to [-lim, +lim]; callers size-cast the result to their width.
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] val,
                                                    input logic signed [63:0] lim);
    logic signed [63:0] res;
    res = val;
    if (val > lim)
      res = lim;
    else if (val < -lim)
      res = -lim;
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sat_signed_clamp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sat_signed_clamp : signed width reduction with symmetric +/-LIMIT clamp      |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module sat_signed_clamp
  import foc_pkg::*;
#(
  parameter int     IN_W  = 17,
  parameter int     OUT_W = 16,
  parameter longint LIMIT = 32767
) (
  input  logic signed [IN_W-1:0]  i_din,
  output logic signed [OUT_W-1:0] o_dout
);

  assign o_dout = OUT_W'(sat_signed(64'(i_din), 64'(LIMIT)));

endmodule
`default_nettype wire

// File: rtl/speed_loop_pi.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | speed_loop_pi : multi-cycle speed PI with shared multiplier and anti-windup  |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module speed_loop_pi
  import foc_pkg::*;
#(
  parameter int P_SHIFT = 8,
  parameter int I_SHIFT = 12,
  parameter int IQ_MAX  = 2047
) (
  input  logic               iClk,
  input  logic               iRst,
  input  logic               iCal_en,
  input  logic               iClr_int,
  input  logic [SPEED_W-1:0] iSpeed_set,
  input  logic [SPEED_W-1:0] iSpeed_fb,
  input  logic [GAIN_W-1:0]  iKp,
  input  logic [GAIN_W-1:0]  iKi,
  output logic [IQ_W-1:0]    oIq_set,
  output logic               oBusy,
  output logic               oCal_done
);

  localparam int     PROD_W      = SPEED_W + GAIN_W + 1;
  localparam longint c_err_lim   = (64'sd1 <<< (SPEED_W - 1)) - 1;
  localparam longint c_integ_lim = longint'(IQ_MAX) <<< I_SHIFT;

  pi_state_e                  state_q, state_d;
  logic signed [SPEED_W-1:0]  set_q, set_d, fb_q, fb_d, err_q, err_d;
  logic        [GAIN_W-1:0]   kp_q, kp_d, ki_q, ki_d;
  logic signed [PROD_W-1:0]   p_q, p_d, di_q, di_d;
  logic signed [31:0]         integ_q, integ_d;
  logic signed [IQ_W-1:0]     iq_q, iq_d;
  logic                       done_q, done_d;

  logic signed [SPEED_W:0]    w_err_wide;
  logic signed [SPEED_W-1:0]  w_err_sat;
  logic        [GAIN_W-1:0]   w_gain;
  logic signed [PROD_W-1:0]   w_prod;
  logic signed [32:0]         w_integ_sum, w_out_sum;
  logic signed [31:0]         w_integ_sat;
  logic signed [IQ_W-1:0]     w_out_sat;

  assign w_err_wide  = (SPEED_W+1)'(set_q) - (SPEED_W+1)'(fb_q);
  // One multiplier serves both terms; the gain operand follows the state.
  assign w_gain      = (state_q == ST_MUL_P) ? kp_q : ki_q;
  assign w_prod      = PROD_W'(err_q) * PROD_W'($signed({1'b0, w_gain}));
  assign w_integ_sum = 33'(integ_q) + 33'(di_q);
  assign w_out_sum   = 33'(p_q) + 33'(integ_q >>> I_SHIFT);

  sat_signed_clamp #(.IN_W(SPEED_W+1), .OUT_W(SPEED_W), .LIMIT(c_err_lim))
    u_err_sat   (.i_din(w_err_wide),  .o_dout(w_err_sat));
  sat_signed_clamp #(.IN_W(33), .OUT_W(32), .LIMIT(c_integ_lim))
    u_integ_sat (.i_din(w_integ_sum), .o_dout(w_integ_sat));
  sat_signed_clamp #(.IN_W(33), .OUT_W(IQ_W), .LIMIT(longint'(IQ_MAX)))
    u_out_sat   (.i_din(w_out_sum),   .o_dout(w_out_sat));

  always_comb begin
    state_d = state_q;
    set_d   = set_q;
    fb_d    = fb_q;
    kp_d    = kp_q;
    ki_d    = ki_q;
    err_d   = err_q;
    p_d     = p_q;
    di_d    = di_q;
    integ_d = integ_q;
    iq_d    = iq_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (iCal_en) begin
          set_d   = $signed(iSpeed_set);
          fb_d    = $signed(iSpeed_fb);
          kp_d    = iKp;
          ki_d    = iKi;
          state_d = ST_ERR;
        end
      end
      ST_ERR: begin
        err_d   = w_err_sat;
        state_d = ST_MUL_P;
      end
      ST_MUL_P: begin
        p_d     = w_prod >>> P_SHIFT;
        state_d = ST_MUL_I;
      end
      ST_MUL_I: begin
        di_d    = w_prod;
        state_d = ST_ACC;
      end
      ST_ACC: begin
        integ_d = w_integ_sat;
        state_d = ST_OUT;
      end
      ST_OUT: begin
        iq_d    = w_out_sat;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Clear overrides any accumulate landing on the same edge.
    if (iClr_int)
      integ_d = '0;
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q <= ST_IDLE;
      set_q   <= '0;
      fb_q    <= '0;
      kp_q    <= '0;
      ki_q    <= '0;
      err_q   <= '0;
      p_q     <= '0;
      di_q    <= '0;
      integ_q <= '0;
      iq_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      set_q   <= set_d;
      fb_q    <= fb_d;
      kp_q    <= kp_d;
      ki_q    <= ki_d;
      err_q   <= err_d;
      p_q     <= p_d;
      di_q    <= di_d;
      integ_q <= integ_d;
      iq_q    <= iq_d;
      done_q  <= done_d;
    end
  end

  assign oIq_set   = iq_q;
  assign oBusy     = (state_q != ST_IDLE);
  assign oCal_done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_speed_loop_pi.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_speed_loop_pi : scoreboard bench for the speed-loop PI regulator          |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_speed_loop_pi;

  logic               iClk = 1'b0;
  logic               iRst = 1'b1;
  logic               iCal_en = 1'b0;
  logic               iClr_int = 1'b0;
  logic signed [15:0] iSpeed_set = '0;
  logic signed [15:0] iSpeed_fb = '0;
  logic [9:0]         iKp = '0;
  logic [9:0]         iKi = '0;
  logic signed [11:0] oIq_set;
  logic               oBusy;
  logic               oCal_done;

  int     checks = 0;
  int     errors = 0;
  longint m_integ = 0;
  int     exp_q[$];

  speed_loop_pi dut (
    .iClk(iClk), .iRst(iRst), .iCal_en(iCal_en), .iClr_int(iClr_int),
    .iSpeed_set(iSpeed_set), .iSpeed_fb(iSpeed_fb), .iKp(iKp), .iKi(iKi),
    .oIq_set(oIq_set), .oBusy(oBusy), .oCal_done(oCal_done)
  );

  always #5 iClk = ~iClk;

  // Reference model of one regulator run, written in plain integer arithmetic.
  function automatic int model_run(int set, int fb, int kp, int ki, bit clr_acc);
    longint err, p, di, sum;
    err = longint'(set) - longint'(fb);
    if (err > 32767) err = 32767;
    if (err < -32768) err = -32768;
    p  = (err * kp) >>> 8;
    di = err * ki;
    if (clr_acc) m_integ = 0;
    else begin
      m_integ = m_integ + di;
      if (m_integ > 2047 * 4096) m_integ = 2047 * 4096;
      if (m_integ < -2047 * 4096) m_integ = -2047 * 4096;
    end
    sum = p + (m_integ >>> 12);
    if (sum > 2047) sum = 2047;
    if (sum < -2047) sum = -2047;
    return int'(sum);
  endfunction

  // Drive one start pulse and wait (bounded) for oCal_done; lat=0 on timeout.
  task automatic do_run(input int set, input int fb, input int kp, input int ki,
                        input int clr_at, output int lat);
    @(negedge iClk);
    iSpeed_set = 16'(set);
    iSpeed_fb  = 16'(fb);
    iKp        = 10'(kp);
    iKi        = 10'(ki);
    iCal_en    = 1'b1;
    exp_q.push_back(model_run(set, fb, kp, ki, clr_at == 4));
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge iClk);
      if (k == 1) iCal_en = 1'b0;
      iClr_int = (clr_at != 0) && (k == clr_at);
      if (oCal_done) begin
        lat = k;
        break;
      end
    end
    iClr_int = 1'b0;
    if (lat == 0) begin
      checks++; errors++;
      $display("FAIL run_timeout done=%b required 1 within 20 clk", oCal_done);
      void'(exp_q.pop_back());
    end
  endtask

  task automatic clear_integ();
    @(negedge iClk);
    iClr_int = 1'b1;
    @(negedge iClk);
    iClr_int = 1'b0;
    m_integ = 0;
  endtask

  task automatic test_reset();
    iRst = 1'b1;
    repeat (2) @(negedge iClk);
    checks++; if (oIq_set !== 12'sd0) begin errors++; $display("FAIL reset_iq got %0d required 0", oIq_set); end
    checks++; if (oBusy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b required 0", oBusy); end
    checks++; if (oCal_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b required 0", oCal_done); end
    iRst = 1'b0;
    m_integ = 0;
  endtask

  task automatic test_proportional();
    int lat, e;
    do_run(1000, 0, 256, 0, 0, lat);
    checks++; if (lat !== 6) begin errors++; $display("FAIL prop_latency got %0d required 6", lat); end
    if (lat != 0) begin
      e = exp_q.pop_front();
      checks++; if (oIq_set !== 12'(e)) begin errors++; $display("FAIL prop_sb got %0d required %0d", oIq_set, e); end
      checks++; if (oIq_set !== 12'sd1000) begin errors++; $display("FAIL prop_value got %0d required 1000", oIq_set); end
      checks++; if (oBusy !== 1'b0) begin errors++; $display("FAIL prop_busy_done got %b required 0", oBusy); end
    end
    repeat (3) @(negedge iClk);
    checks++; if (oIq_set !== 12'sd1000) begin errors++; $display("FAIL prop_hold got %0d required 1000", oIq_set); end
  endtask

  task automatic test_saturation();
    int lat, e;
    do_run(30000, -30000, 256, 0, 0, lat);
    if (lat != 0) begin
      e = exp_q.pop_front();
      checks++; if (oIq_set !== 12'(e)) begin errors++; $display("FAIL sat_pos_sb got %0d required %0d", oIq_set, e); end
      checks++; if (oIq_set !== 12'sd2047) begin errors++; $display("FAIL sat_pos got %0d required 2047", oIq_set); end
    end
    do_run(-30000, 30000, 256, 0, 0, lat);
    if (lat != 0) begin
      e = exp_q.pop_front();
      checks++; if (oIq_set !== 12'(e)) begin errors++; $display("FAIL sat_neg_sb got %0d required %0d", oIq_set, e); end
      checks++; if (oIq_set !== -12'sd2047) begin errors++; $display("FAIL sat_neg got %0d required -2047", oIq_set); end
    end
  endtask

  task automatic test_integral();
    int lat, e;
    clear_integ();
    for (int r = 1; r <= 3; r++) begin
      do_run(400, 0, 0, 512, 0, lat);
      if (lat != 0) begin
        e = exp_q.pop_front();
        checks++; if (oIq_set !== 12'(e)) begin errors++; $display("FAIL integ_sb run %0d got %0d required %0d", r, oIq_set, e); end
        checks++; if (oIq_set !== 12'(50 * r)) begin errors++; $display("FAIL integ_run run %0d got %0d required %0d", r, oIq_set, 50 * r); end
      end
    end
  endtask

  task automatic test_windup();
    int lat, e;
    for (int r = 4; r <= 200; r++) begin
      do_run(400, 0, 0, 512, 0, lat);
      if (lat != 0) begin
        e = exp_q.pop_front();
        checks++; if (oIq_set !== 12'(e)) begin errors++; $display("FAIL windup_sb run %0d got %0d required %0d", r, oIq_set, e); end
      end
    end
    checks++; if (oIq_set !== 12'sd2047) begin errors++; $display("FAIL windup_limit got %0d required 2047", oIq_set); end
    do_run(-400, 0, 0, 512, 0, lat);
    if (lat != 0) begin
      e = exp_q.pop_front();
      checks++; if (oIq_set !== 12'(e)) begin errors++; $display("FAIL windup_rec_sb got %0d required %0d", oIq_set, e); end
      checks++; if (oIq_set !== 12'sd1997) begin errors++; $display("FAIL windup_recover got %0d required 1997", oIq_set); end
    end
  endtask

  task automatic test_back_to_back();
    int e;
    logic exp_done, exp_busy;
    clear_integ();
    @(negedge iClk);
    iSpeed_set = 16'sd100;
    iSpeed_fb  = 16'sd0;
    iKp        = 10'd256;
    iKi        = 10'd0;
    iCal_en    = 1'b1;
    exp_q.push_back(model_run(100, 0, 256, 0, 1'b0));
    for (int k = 1; k <= 30; k++) begin
      @(negedge iClk);
      // Input wiggles mid-run must not reach the latched operands.
      if (k == 3) iSpeed_set = 16'sd200;
      if (k == 5) iSpeed_set = 16'sd100;
      if (k == 23) iCal_en = 1'b0;
      exp_done = (k % 6 == 0) && (k <= 24);
      exp_busy = (k < 24) && (k % 6 != 0);
      checks++; if (oCal_done !== exp_done) begin errors++; $display("FAIL b2b_done clk %0d got %b required %b", k, oCal_done, exp_done); end
      checks++; if (oBusy !== exp_busy) begin errors++; $display("FAIL b2b_busy clk %0d got %b required %b", k, oBusy, exp_busy); end
      if (oCal_done && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++; if (oIq_set !== 12'(e)) begin errors++; $display("FAIL b2b_sb clk %0d got %0d required %0d", k, oIq_set, e); end
        checks++; if (oIq_set !== 12'sd100) begin errors++; $display("FAIL b2b_value clk %0d got %0d required 100", k, oIq_set); end
      end
      if ((k % 6 == 0) && (k < 24)) exp_q.push_back(model_run(100, 0, 256, 0, 1'b0));
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_pending got %0d required 0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_reset_mid_run();
    int lat, e, n_done;
    do_run(500, 0, 256, 0, 0, lat);
    if (lat != 0) begin
      e = exp_q.pop_front();
      checks++; if (oIq_set !== 12'(e)) begin errors++; $display("FAIL rst_pre_sb got %0d required %0d", oIq_set, e); end
    end
    @(negedge iClk);
    iSpeed_set = 16'sd700;
    iKi        = 10'd100;
    iCal_en    = 1'b1;
    @(negedge iClk);
    iCal_en = 1'b0;
    repeat (2) @(negedge iClk);
    iRst = 1'b1;
    #1;
    m_integ = 0;
    checks++; if (oIq_set !== 12'sd0) begin errors++; $display("FAIL rst_mid_iq got %0d required 0", oIq_set); end
    checks++; if (oBusy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b required 0", oBusy); end
    @(negedge iClk);
    iRst = 1'b0;
    n_done = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge iClk);
      if (oCal_done) n_done++;
    end
    checks++; if (n_done !== 0) begin errors++; $display("FAIL rst_mid_done got %0d pulses required 0", n_done); end
    do_run(300, 0, 256, 0, 0, lat);
    if (lat != 0) begin
      e = exp_q.pop_front();
      checks++; if (oIq_set !== 12'sd300) begin errors++; $display("FAIL rst_post_run got %0d required 300", oIq_set); end
      checks++; if (oIq_set !== 12'(e)) begin errors++; $display("FAIL rst_post_sb got %0d required %0d", oIq_set, e); end
    end
  endtask

  task automatic test_clr_int();
    int lat, e;
    clear_integ();
    for (int r = 1; r <= 2; r++) begin
      do_run(400, 0, 0, 512, 0, lat);
      if (lat != 0) begin
        e = exp_q.pop_front();
        checks++; if (oIq_set !== 12'(e)) begin errors++; $display("FAIL clr_pre_sb run %0d got %0d required %0d", r, oIq_set, e); end
      end
    end
    do_run(400, 0, 256, 512, 4, lat);
    if (lat != 0) begin
      e = exp_q.pop_front();
      checks++; if (oIq_set !== 12'(e)) begin errors++; $display("FAIL clr_acc_sb got %0d required %0d", oIq_set, e); end
      checks++; if (oIq_set !== 12'sd400) begin errors++; $display("FAIL clr_acc_p_only got %0d required 400", oIq_set); end
    end
    do_run(400, 0, 0, 512, 0, lat);
    if (lat != 0) begin
      e = exp_q.pop_front();
      checks++; if (oIq_set !== 12'sd50) begin errors++; $display("FAIL clr_after got %0d required 50", oIq_set); end
      checks++; if (oIq_set !== 12'(e)) begin errors++; $display("FAIL clr_after_sb got %0d required %0d", oIq_set, e); end
    end
  endtask

  initial begin
    test_reset();
    test_proportional();
    test_saturation();
    test_integral();
    test_windup();
    test_back_to_back();
    test_reset_mid_run();
    test_clr_int();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout sim time exceeded, checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
